// File: rtl/ac3_multi.sv
// Third-stage accumulator with NCH channels. It accumulates signed AC2 partial sums per channel,
// quantises every channel to Pa bits, and streams the results out one channel per beat.
module ac3_multi #(
  parameter int M   = 16,
  parameter int Pa  = 8,
  parameter int Pw  = 4,
  parameter int MNO = 288,
  parameter int NCH = 4,
  parameter int IW  = $clog2(M) + Pa + Pw,
  parameter int AW  = IW + $clog2(MNO),
  parameter int CW  = $clog2(NCH),
  parameter int NW  = $clog2(MNO + 1),
  parameter int SW  = $clog2(AW)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NW-1:0]     num_ops,
  input  logic [SW-1:0]     shamt,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW-1:0]     in_ch,
  input  logic [IW-1:0]     in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [Pa-1:0]     out_data,
  output logic [CW-1:0]     out_ch,
  output logic              out_last,
  output logic              out_sat,
  output logic              busy,
  output logic              err_extra
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    QUANT = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Saturation bounds; QMIN is the bitwise complement of QMAX in two's complement.
  localparam logic signed [AW:0] QMAX = $signed((AW + 1)'((1 << (Pa - 1)) - 1));
  localparam logic signed [AW:0] QMIN = ~QMAX;

  state_t            state_reg;
  logic [NW-1:0]     num_ops_reg;
  logic [SW-1:0]     shamt_reg;
  logic [AW-1:0]     acc_reg      [NCH];
  logic [NW-1:0]     cnt_reg      [NCH];
  logic [Pa-1:0]     res_data_reg [NCH];
  logic              res_sat_reg  [NCH];

  logic [NW-1:0]     num_ops_clamped;
  logic              beat_ok;
  logic              beat_extra;
  logic [NCH-1:0]    ch_done_next;
  logic [NCH-1:0]    q_sat;
  logic [NCH-1:0][Pa-1:0] q_data;
  logic [CW-1:0]     ch_inc;
  logic [AW-1:0]     in_ext;

  assign num_ops_clamped = (num_ops > NW'(MNO)) ? NW'(MNO) : num_ops;
  assign beat_ok         = in_valid && in_ready && (cnt_reg[in_ch] < num_ops_reg);
  assign beat_extra      = in_valid && in_ready && !(cnt_reg[in_ch] < num_ops_reg);
  assign ch_inc          = out_ch + CW'(1);
  assign in_ext          = {{(AW - IW){in_data[IW-1]}}, in_data};

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [NW-1:0]     cnt_nx;
      logic [AW:0]       rnd;
      logic signed [AW:0] q_ext;
      logic signed [AW:0] q_sum;
      logic signed [AW:0] q_shift;

      // Count as it will stand after this cycle's beat; lets ACC leave on the completing beat.
      assign cnt_nx = (beat_ok && (in_ch == CW'(gi))) ? cnt_reg[gi] + NW'(1) : cnt_reg[gi];
      assign ch_done_next[gi] = (cnt_nx == num_ops_reg);

      // Half-LSB rounding constant (zero when shamt is zero), added one bit wider than the accumulator.
      assign rnd     = ({{AW{1'b0}}, 1'b1} << shamt_reg) >> 1;
      assign q_ext   = $signed({acc_reg[gi][AW-1], acc_reg[gi]});
      assign q_sum   = q_ext + $signed(rnd);
      assign q_shift = q_sum >>> shamt_reg;

      assign q_sat[gi]  = (q_shift > QMAX) || (q_shift < QMIN);
      assign q_data[gi] = (q_shift > QMAX) ? QMAX[Pa-1:0] :
                          (q_shift < QMIN) ? QMIN[Pa-1:0] : q_shift[Pa-1:0];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      num_ops_reg <= '0;
      shamt_reg   <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_ch      <= '0;
      out_last    <= 1'b0;
      out_sat     <= 1'b0;
      busy        <= 1'b0;
      err_extra   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        acc_reg[i]      <= '0;
        cnt_reg[i]      <= '0;
        res_data_reg[i] <= '0;
        res_sat_reg[i]  <= 1'b0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            num_ops_reg <= num_ops_clamped;
            shamt_reg   <= shamt;
            err_extra   <= 1'b0;
            busy        <= 1'b1;
            for (int i = 0; i < NCH; i++) begin
              acc_reg[i] <= '0;
              cnt_reg[i] <= '0;
            end
            if (num_ops_clamped == '0) begin
              state_reg <= QUANT;
              in_ready  <= 1'b0;
            end else begin
              state_reg <= ACC;
              in_ready  <= 1'b1;
            end
          end
        end

        ACC: begin
          if (beat_ok) begin
            acc_reg[in_ch] <= acc_reg[in_ch] + in_ext;
            cnt_reg[in_ch] <= cnt_reg[in_ch] + NW'(1);
          end
          if (beat_extra) begin
            err_extra <= 1'b1;
          end
          if (&ch_done_next) begin
            state_reg <= QUANT;
            in_ready  <= 1'b0;
          end
        end

        QUANT: begin
          for (int i = 0; i < NCH; i++) begin
            res_data_reg[i] <= q_data[i];
            res_sat_reg[i]  <= q_sat[i];
          end
          // Channel 0 is presented straight from the quantiser so OUT starts with valid data.
          out_valid <= 1'b1;
          out_ch    <= '0;
          out_data  <= q_data[0];
          out_sat   <= q_sat[0];
          out_last  <= 1'b0;
          state_reg <= OUT;
        end

        OUT: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              out_sat   <= 1'b0;
              out_ch    <= '0;
              busy      <= 1'b0;
              state_reg <= IDLE;
            end else begin
              out_ch   <= ch_inc;
              out_data <= res_data_reg[ch_inc];
              out_sat  <= res_sat_reg[ch_inc];
              out_last <= (ch_inc == CW'(NCH - 1));
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ac3_multi.sv
// Directed bench for ac3_multi: hand-computed pass results, rounding, saturation,
// extra beats, output backpressure and reset mid-pass.
module tb_ac3_multi;
  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  num_ops;
  logic [4:0]  shamt;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_ch;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_last;
  logic        out_sat;
  logic        busy;
  logic        err_extra;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_d [NCH];
  int exp_s [NCH];

  ac3_multi dut (
    .clk(clk), .rst(rst), .start(start), .num_ops(num_ops), .shamt(shamt),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .out_last(out_last), .out_sat(out_sat), .busy(busy), .err_extra(err_extra)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass(input int n, input int sh);
    start   = 1'b1;
    num_ops = 9'(n);
    shamt   = 5'(sh);
    tick();
    start   = 1'b0;
  endtask

  task automatic send_beat(input int ch, input int d);
    in_valid = 1'b1;
    in_ch    = 2'(ch);
    in_data  = 16'(d);
    tick();
    in_valid = 1'b0;
  endtask

  // Drain all channels with out_ready held high, then confirm the return to IDLE.
  task automatic collect(input string name);
    out_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      int w = 0;
      while (!out_valid && w < 20) begin
        tick();
        w++;
      end
      check_eq({name, "_valid"}, int'(out_valid), 1);
      check_eq({name, "_data"}, int'($signed(out_data)), exp_d[i]);
      check_eq({name, "_ch"}, int'(out_ch), i);
      check_eq({name, "_sat"}, int'(out_sat), exp_s[i]);
      check_eq({name, "_last"}, int'(out_last), (i == NCH - 1) ? 1 : 0);
      $display("%s: ch=%0d data=%0d sat=%0d last=%0d", name, out_ch, $signed(out_data), out_sat, out_last);
      tick();
    end
    out_ready = 1'b0;
    check_eq({name, "_busy_after"}, int'(busy), 0);
    check_eq({name, "_valid_after"}, int'(out_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; num_ops = '0; shamt = '0;
    in_valid = 1'b0; in_ch = '0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_in_ready", int'(in_ready), 0);
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_err", int'(err_extra), 0);
    rst = 1'b0;
    tick();

    // 1: round-robin accumulation, 3 operands per channel, latency of out_valid
    start_pass(3, 0);
    check_eq("t1_busy", int'(busy), 1);
    check_eq("t1_in_ready", int'(in_ready), 1);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < NCH; c++) send_beat(c, 10 * (c + 1));
    check_eq("t1_valid_t1", int'(out_valid), 0);
    check_eq("t1_in_ready_quant", int'(in_ready), 0);
    tick();
    check_eq("t1_valid_t2", int'(out_valid), 1);
    exp_d = '{30, 60, 90, 120}; exp_s = '{0, 0, 0, 0};
    collect("t1");

    // 2: round-half-up before arithmetic shift
    start_pass(1, 2);
    send_beat(0, 6); send_beat(1, -6); send_beat(2, 5); send_beat(3, -5);
    exp_d = '{2, -1, 1, -1}; exp_s = '{0, 0, 0, 0};
    collect("t2");

    // 3: positive and negative saturation
    start_pass(2, 0);
    send_beat(0, 500); send_beat(1, -300); send_beat(2, 0); send_beat(3, 0);
    send_beat(0, 500); send_beat(1, -300); send_beat(2, 0); send_beat(3, 0);
    exp_d = '{127, -128, 0, 0}; exp_s = '{1, 1, 0, 0};
    collect("t3");

    // 4: extra beat on an already-complete channel is dropped and flagged
    start_pass(1, 0);
    send_beat(2, 9);
    send_beat(2, 50);
    check_eq("t4_err_set", int'(err_extra), 1);
    send_beat(0, 1); send_beat(1, 2); send_beat(3, 3);
    exp_d = '{1, 2, 9, 3}; exp_s = '{0, 0, 0, 0};
    collect("t4");
    check_eq("t4_err_sticky", int'(err_extra), 1);

    // 5: backpressure in OUT, plus a start pulse that must be ignored there
    start_pass(1, 0);
    check_eq("t5_err_cleared", int'(err_extra), 0);
    send_beat(0, -7); send_beat(1, 100); send_beat(2, 200); send_beat(3, -1);
    tick();
    for (int k = 0; k < 5; k++) begin
      check_eq("t5_hold_data", int'($signed(out_data)), -7);
      check_eq("t5_hold_ch", int'(out_ch), 0);
      if (k == 2) start = 1'b1;
      tick();
      start = 1'b0;
    end
    check_eq("t5_start_ignored_busy", int'(busy), 1);
    check_eq("t5_start_ignored_valid", int'(out_valid), 1);
    exp_d = '{-7, 100, 127, -1}; exp_s = '{0, 0, 1, 0};
    collect("t5");

    // 6: reset mid-ACC leaves no residue
    start_pass(2, 0);
    send_beat(0, 100); send_beat(1, 100);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_busy", int'(busy), 0);
    check_eq("t6_rst_in_ready", int'(in_ready), 0);
    tick();
    rst = 1'b0;
    tick();
    start_pass(1, 0);
    for (int c = 0; c < NCH; c++) send_beat(c, 7);
    exp_d = '{7, 7, 7, 7}; exp_s = '{0, 0, 0, 0};
    collect("t6");

    // 7: zero operands goes straight to QUANT, all results zero
    start_pass(0, 0);
    check_eq("t7_in_ready", int'(in_ready), 0);
    check_eq("t7_busy", int'(busy), 1);
    exp_d = '{0, 0, 0, 0}; exp_s = '{0, 0, 0, 0};
    collect("t7");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
